// File: rtl/ram_bist.sv
// March-style self-test engine for a single-port RAM: write P up, read P up, write ~P down, read ~P down.
// Optional macro RAM_BIST_ERRCOUNT_EN adds an error counter and runs all elements instead of stopping at the first failure.
module ram_bist #(
   parameter int                ADDR_W     = 8,
   parameter int                DATA_W     = 8,
   parameter logic [DATA_W-1:0] PATTERN    = 'hA5,
   parameter int                RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] failaddr,
   output logic [DATA_W-1:0] faildata,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] din,
   output logic              en,
   output logic              we,
   input  logic [DATA_W-1:0] dout
`ifdef RAM_BIST_ERRCOUNT_EN
   ,
   output logic [7:0]        errcount
`endif
);

   localparam int CW = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);
   localparam logic [CW-1:0]     LAT       = CW'(RD_LATENCY);
   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

   typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DONE} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr_nx, failaddr_nx;
   logic [DATA_W-1:0] din_nx, faildata_nx, expect_data;
   logic              en_nx, we_nx, busy_nx, done_nx, pass_nx;
   logic [CW-1:0]     waitcnt, waitcnt_nx;
   logic              mismatch, last_addr, finish, advance;
`ifdef RAM_BIST_ERRCOUNT_EN
   logic [7:0]        errcount_nx;
`endif

   // Every output is a register; this block computes the next value of all of them.
   always_comb begin
      state_nx    = state;
      addr_nx     = addr;
      din_nx      = din;
      en_nx       = en;
      we_nx       = we;
      busy_nx     = busy;
      done_nx     = done;
      pass_nx     = pass;
      failaddr_nx = failaddr;
      faildata_nx = faildata;
      waitcnt_nx  = waitcnt;
`ifdef RAM_BIST_ERRCOUNT_EN
      errcount_nx = errcount;
`endif
      expect_data = (state == R1) ? ~PATTERN : PATTERN;
      mismatch    = (dout != expect_data);
      last_addr   = (state == R1 || state == W1) ? (addr == '0) : (addr == ADDR_LAST);
      finish      = 1'b0;
      advance     = 1'b0;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nx    = W0;
               busy_nx     = 1'b1;
               done_nx     = 1'b0;
               pass_nx     = 1'b0;
               failaddr_nx = '0;
               faildata_nx = '0;
               addr_nx     = '0;
               din_nx      = PATTERN;
               en_nx       = 1'b1;
               we_nx       = 1'b1;
               waitcnt_nx  = '0;
`ifdef RAM_BIST_ERRCOUNT_EN
               errcount_nx = 8'd0;
`endif
            end
         end
         W0: begin
            if (last_addr) begin
               state_nx = R0;
               addr_nx  = '0;
               we_nx    = 1'b0;
            end else begin
               addr_nx = addr + 1'b1;
            end
         end
         W1: begin
            if (last_addr) begin
               state_nx = R1;
               addr_nx  = ADDR_LAST;
               we_nx    = 1'b0;
            end else begin
               addr_nx = addr - 1'b1;
            end
         end
         R0, R1: begin
            // en high marks the issue cycle; the compare waits until the last latency cycle.
            if (en) begin
               en_nx      = 1'b0;
               waitcnt_nx = CW'(1);
            end else if (waitcnt != LAT) begin
               waitcnt_nx = waitcnt + 1'b1;
            end else begin
`ifdef RAM_BIST_ERRCOUNT_EN
               if (mismatch) begin
                  if (errcount == 8'd0) begin
                     failaddr_nx = addr;
                     faildata_nx = dout;
                  end
                  if (errcount != 8'hFF) errcount_nx = errcount + 8'd1;
               end
               advance = 1'b1;
`else
               if (mismatch) begin
                  failaddr_nx = addr;
                  faildata_nx = dout;
                  pass_nx     = 1'b0;
                  finish      = 1'b1;
               end else begin
                  advance = 1'b1;
               end
`endif
               if (advance) begin
                  if (!last_addr) begin
                     addr_nx = (state == R0) ? addr + 1'b1 : addr - 1'b1;
                     en_nx   = 1'b1;
                  end else if (state == R0) begin
                     state_nx = W1;
                     addr_nx  = ADDR_LAST;
                     din_nx   = ~PATTERN;
                     en_nx    = 1'b1;
                     we_nx    = 1'b1;
                  end else begin
                     pass_nx = 1'b1;
                     finish  = 1'b1;
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase

      if (finish) begin
         state_nx = DONE;
         busy_nx  = 1'b0;
         done_nx  = 1'b1;
         en_nx    = 1'b0;
         we_nx    = 1'b0;
`ifdef RAM_BIST_ERRCOUNT_EN
         pass_nx  = (errcount_nx == 8'd0);
`endif
      end
   end

   // Reset aborts any run in progress and discards partial results.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         addr     <= '0;
         din      <= '0;
         en       <= 1'b0;
         we       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         failaddr <= '0;
         faildata <= '0;
         waitcnt  <= '0;
`ifdef RAM_BIST_ERRCOUNT_EN
         errcount <= 8'd0;
`endif
      end else begin
         state    <= state_nx;
         addr     <= addr_nx;
         din      <= din_nx;
         en       <= en_nx;
         we       <= we_nx;
         busy     <= busy_nx;
         done     <= done_nx;
         pass     <= pass_nx;
         failaddr <= failaddr_nx;
         faildata <= faildata_nx;
         waitcnt  <= waitcnt_nx;
`ifdef RAM_BIST_ERRCOUNT_EN
         errcount <= errcount_nx;
`endif
      end
   end

endmodule

// File: tb/tb_ram_bist.sv
// Scoreboard bench for ram_bist: behavioural 256x8 RAM with per-address stuck-at fault masks.
// Expected run results are queued by the stimulus and checked by a monitor when done rises.
module tb_ram_bist;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, pass, en, we;
   logic [7:0] failaddr, faildata, addr, din, dout;
`ifdef RAM_BIST_ERRCOUNT_EN
   logic [7:0] errcount;
`endif

   logic [7:0] mem [256];
   logic [7:0] stuck0 [256];
   logic [7:0] stuck1 [256];

   typedef struct {
      logic       pass;
      logic [7:0] fa;
      logic [7:0] fd;
      int         cycles;
      logic [7:0] ec;
   } exp_t;

   exp_t        sbQ[$];
   string       nameQ[$];
   logic [31:0] actQ[$];
   logic [31:0] expQ[$];

   int nChecks = 0;
   int nFails  = 0;

   always #5 clk = ~clk;

   ram_bist dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
      .failaddr(failaddr), .faildata(faildata), .addr(addr), .din(din),
      .en(en), .we(we), .dout(dout)
`ifdef RAM_BIST_ERRCOUNT_EN
      , .errcount(errcount)
`endif
   );

   // RAM model, read latency 1, faults applied on the read path
   always @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= din;
         else    dout <= (mem[addr] & ~stuck0[addr]) | stuck1[addr];
      end
   end

   function automatic void compare(string name, logic [31:0] act, logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      nameQ.push_back(name);
      actQ.push_back(act);
      expQ.push_back(exp);
   endtask

   task automatic applyStimulus();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic clearFaults();
      for (int i = 0; i < 256; i++) begin
         stuck0[i] = 8'h00;
         stuck1[i] = 8'h00;
      end
   endtask

   task automatic expectRun(logic p, logic [7:0] fa, logic [7:0] fd, int cyc, logic [7:0] ec);
      exp_t e;
      e.pass = p; e.fa = fa; e.fd = fd; e.cycles = cyc; e.ec = ec;
      sbQ.push_back(e);
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: drains direct checks and scores each completed run when done rises
   initial begin : monitor
      logic prevBusy, prevDone;
      int   busyCycles;
      exp_t e;
      prevBusy = 1'b0;
      prevDone = 1'b0;
      busyCycles = 0;
      forever begin
         @(negedge clk);
         while (nameQ.size() > 0) compare(nameQ.pop_front(), actQ.pop_front(), expQ.pop_front());
         if (busy && !prevBusy) busyCycles = 1;
         else if (busy) busyCycles++;
         if (done && !prevDone) begin
            if (sbQ.size() == 0) begin
               compare("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sbQ.pop_front();
               compare("pass", {31'd0, pass}, {31'd0, e.pass});
               compare("failaddr", {24'd0, failaddr}, {24'd0, e.fa});
               compare("faildata", {24'd0, faildata}, {24'd0, e.fd});
               compare("busy_cycles", busyCycles, e.cycles);
`ifdef RAM_BIST_ERRCOUNT_EN
               compare("errcount", {24'd0, errcount}, {24'd0, e.ec});
`endif
            end
         end
         prevBusy = busy;
         prevDone = done;
      end
   end

   initial begin : stimulus
      int bad;
      int cyc40, cyc02;
`ifdef RAM_BIST_ERRCOUNT_EN
      cyc40 = 1536;
      cyc02 = 1536;
`else
      cyc40 = 1024 + 192 * 2;
      cyc02 = 1024 + 254 * 2;
`endif
      clearFaults();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_pass", {31'd0, pass}, 32'd0);
      checkOutput("rst_en", {31'd0, en}, 32'd0);
      checkOutput("rst_we", {31'd0, we}, 32'd0);
      checkOutput("rst_addr", {24'd0, addr}, 32'd0);
      checkOutput("rst_din", {24'd0, din}, 32'd0);
      checkOutput("rst_failaddr", {24'd0, failaddr}, 32'd0);
      checkOutput("rst_faildata", {24'd0, faildata}, 32'd0);
      @(negedge clk);

      $display("[TB] clean run");
      expectRun(1'b1, 8'h00, 8'h00, 1536, 8'd0);
      applyStimulus();
      checkOutput("first_write_en", {31'd0, en & we}, 32'd1);
      checkOutput("first_write_din", {24'd0, din}, 32'hA5);
      waitDone();
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== 8'h5A) bad++;
      checkOutput("mem_5a_bad_locations", bad, 32'd0);
      repeat (5) @(negedge clk);
      checkOutput("done_held", {31'd0, done}, 32'd1);
      checkOutput("idle_en", {31'd0, en}, 32'd0);

      $display("[TB] addr 40 bit3 stuck-at-0");
      stuck0[8'h40] = 8'h08;
      expectRun(1'b0, 8'h40, 8'h52, cyc40, 8'd1);
      applyStimulus();
      checkOutput("done_cleared_on_start", {31'd0, done}, 32'd0);
      checkOutput("busy_on_start", {31'd0, busy}, 32'd1);
      waitDone();
      clearFaults();
      @(negedge clk);

      $display("[TB] addr 02 bit0 stuck-at-1");
      stuck1[8'h02] = 8'h01;
      expectRun(1'b0, 8'h02, 8'h5B, cyc02, 8'd1);
      applyStimulus();
      waitDone();
      clearFaults();
      @(negedge clk);

      $display("[TB] reset mid-run");
      applyStimulus();
      repeat (298) @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      checkOutput("abort_en", {31'd0, en}, 32'd0);
      checkOutput("abort_we", {31'd0, we}, 32'd0);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_done", {31'd0, done}, 32'd0);
      checkOutput("abort_failaddr", {24'd0, failaddr}, 32'd0);
      @(negedge clk);
      checkOutput("abort_stays_idle", {31'd0, busy}, 32'd0);
      expectRun(1'b1, 8'h00, 8'h00, 1536, 8'd0);
      applyStimulus();
      waitDone();
      @(negedge clk);

      $display("[TB] start re-pulsed while busy");
      expectRun(1'b1, 8'h00, 8'h00, 1536, 8'd0);
      applyStimulus();
      repeat (100) @(negedge clk);
      applyStimulus();
      repeat (600) @(negedge clk);
      applyStimulus();
      waitDone();
      @(negedge clk);

`ifdef RAM_BIST_ERRCOUNT_EN
      $display("[TB] two bit7 stuck-at-1 faults, error counting");
      stuck1[8'h10] = 8'h80;
      stuck1[8'h20] = 8'h80;
      expectRun(1'b0, 8'h20, 8'hDA, 1536, 8'd2);
      applyStimulus();
      waitDone();
      clearFaults();
      @(negedge clk);
`endif

      checkOutput("scoreboard_empty", sbQ.size(), 32'd0);
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
